pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Control-side counterpart of the program counter register: generates the register's load and output-enable strobes and its load data.
- Reads the current PC back over the shared A bus, fetches the instruction word from memory with a req/ack handshake, and presents it downstream with a valid/ready handshake.
- Writes the next PC (PC+STEP or a branch target) back into the register.
- Sits between the PC register, instruction memory and the decode stage.

Parameters:
WIDTH, 16, PC/address and instruction word width
STEP, 1, PC increment per fetched instruction

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  fetch enable; sampled in IDLE and UPDATE
pc_bus  input  WIDTH  shared A bus; carries PC value while pc_oeA=1
pc_ld  output  1  load strobe to PC register
pc_din  output  WIDTH  next-PC data to PC register
pc_oeA  output  1  PC register A-bus output enable
pc_oeB  output  1  PC register B-bus output enable (debug read)
dbg_rd  input  1  debug request to expose PC on B bus
mem_req  output  1  instruction memory request
mem_addr  output  WIDTH  instruction address
mem_ack  input  1  memory acknowledge; rdata valid same cycle
mem_rdata  input  WIDTH  instruction word
ir  output  WIDTH  fetched instruction
ir_valid  output  1  ir holds an unconsumed instruction
ir_ready  input  1  downstream accepts ir
br_valid  input  1  single-cycle branch request
br_target  input  WIDTH  branch target PC
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pc_q, ir, br_pend_tgt=0; br_pend=0. All outputs 0 immediately, including mem_req and pc_ld. A reset mid-fetch abandons the transaction; a late mem_ack after release is ignored because the block is in IDLE.
- State machine, one-hot or encoded, all outputs decoded from registered state/data (Moore):
  - IDLE: en=1 -> RD_PC, else stay.
  - RD_PC: pc_oeA=1 for exactly 1 cycle; pc_q<=pc_bus at the edge ending the cycle; -> FETCH.
  - FETCH: mem_req=1, mem_addr=pc_q, held stable until mem_ack. On mem_ack: ir<=mem_rdata, -> ISSUE. Wait is unbounded.
  - ISSUE: ir_valid=1; ir stable. On ir_ready: -> UPDATE. If ir_ready=1 on the first ISSUE cycle, exactly 1 ISSUE cycle.
  - UPDATE: pc_ld=1 for 1 cycle. pc_din priority: br_valid this cycle ? br_target : br_pend ? br_pend_tgt : pc_q+STEP. br_pend cleared. Next state: en ? RD_PC : IDLE.
- Minimum loop latency: 4 cycles per instruction (RD_PC, FETCH with same-cycle ack, ISSUE with ready, UPDATE).
- pc_din is driven to the selected next-PC only in UPDATE and is 0 otherwise.
- Arithmetic: pc_q+STEP is modulo 2^WIDTH. 16'hFFFF+1 -> 16'h0000, no flag.
- Branch capture:
  - br_valid in any state other than UPDATE sets br_pend=1 and br_pend_tgt=br_target.
  - Multiple branches before UPDATE: the last one wins.
  - A branch does not squash the instruction already in FETCH or ISSUE.
  - br_valid in IDLE is retained and applied at the next UPDATE.
- pc_oeB = dbg_rd & (state==IDLE). pc_oeA and pc_oeB are never both 1, so there is no contention on the shared register output.
- en deasserted mid-loop: the current instruction completes through UPDATE, then IDLE.
- ir retains its last value after ISSUE; ir_valid=0 outside ISSUE.

Decomposition:
- Shared package/header: state encodings (S_IDLE, S_RD_PC, S_FETCH, S_ISSUE, S_UPDATE) and the default WIDTH.
- One sub-module: pc_next_sel, a combinational next-PC mux/incrementer (pc_q, STEP, branch inputs -> pc_din). Everything else lives in pc_fetch_ctrl.

Test Plan:
- Reset then en=1, pc_bus=16'h0010 during RD_PC, mem_ack same cycle with rdata=16'hA5A5, ir_ready=1 -> mem_addr=16'h0010, ir=16'hA5A5, pc_ld pulse with pc_din=16'h0011, 4-cycle period.
- pc_bus=16'hFFFF -> UPDATE drives pc_din=16'h0000.
- br_valid with target 16'h0200 during FETCH, then a second br_valid with 16'h0300 during ISSUE -> pc_din=16'h0300 and br_pend cleared; the next loop increments normally.
- br_valid with target 16'h0400 in the UPDATE cycle while br_pend holds 16'h0300 -> pc_din=16'h0400.
- mem_ack delayed 3 cycles, ir_ready delayed 2 cycles -> mem_req/mem_addr stable and ir_valid/ir stable throughout; exactly one pc_ld per instruction.
- Drive reset low during FETCH -> mem_req, pc_oeA and pc_ld go to 0 without waiting for a clock edge. Drive dbg_rd=1 in IDLE -> pc_oeB=1. Drive dbg_rd=1 in RD_PC -> pc_oeB=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch controller: default sizes and FSM state encodings.
package pc_fetch_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_STEP  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PC,
        S_FETCH,
        S_ISSUE,
        S_UPDATE
    } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: a fresh branch beats a pending branch, which beats the sequential increment.
module pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic [WIDTH-1:0] pc_q,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             br_pend,
    input  logic [WIDTH-1:0] br_pend_tgt,
    output logic [WIDTH-1:0] next_pc
);

    // Priority mux; the increment wraps modulo 2^WIDTH with no carry out.
    always_comb begin
        next_pc = pc_q + WIDTH'(STEP);
        if (br_valid) begin
            next_pc = br_target;
        end else if (br_pend) begin
            next_pc = br_pend_tgt;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: reads the PC register over the A bus, fetches the instruction from
// memory, hands it downstream, then writes the next PC back into the register.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] pc_bus,
    output logic             pc_ld,
    output logic [WIDTH-1:0] pc_din,
    output logic             pc_oeA,
    output logic             pc_oeB,
    input  logic             dbg_rd,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic             br_pend;
    logic [WIDTH-1:0] br_pend_tgt;
    logic [WIDTH-1:0] next_pc;

    pc_next_sel #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next_sel (
        .pc_q        (pc_q),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .br_pend     (br_pend),
        .br_pend_tgt (br_pend_tgt),
        .next_pc     (next_pc)
    );

    // State register; reset abandons any in-flight fetch by returning straight to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: captured PC, instruction word and the pending-branch slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            br_pend     <= 1'b0;
            br_pend_tgt <= '0;
        end else begin
            if (state == S_RD_PC) begin
                pc_q <= pc_bus;
            end
            if ((state == S_FETCH) && mem_ack) begin
                ir_q <= mem_rdata;
            end
            if (state == S_UPDATE) begin
                br_pend <= 1'b0;
            end else if (br_valid) begin
                br_pend     <= 1'b1;
                br_pend_tgt <= br_target;
            end
        end
    end

    // Next-state logic and Moore output decode; pc_oeB can only fire in IDLE, so it never overlaps pc_oeA.
    always_comb begin
        state_next = state;
        pc_ld      = 1'b0;
        pc_din     = '0;
        pc_oeA     = 1'b0;
        pc_oeB     = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        ir_valid   = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                pc_oeB = dbg_rd & reset;
                if (en) begin
                    state_next = S_RD_PC;
                end
            end
            S_RD_PC: begin
                pc_oeA     = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ir_valid = 1'b1;
                if (ir_ready) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                pc_ld      = 1'b1;
                pc_din     = next_pc;
                state_next = en ? S_RD_PC : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ir = ir_q;

endmodule
